// File: rtl/if_id_skid_stage.sv
// IF->ID pipeline stage built as a two-entry skid register.
// Fetch and decode handshake with valid/ready. Both ready and valid are
// decoded from registered state only, so no combinational path crosses the
// stage. A flush kills everything held and anything arriving in that cycle.
// While nothing valid is held, decode sees a PC of zero and a NOP.
module if_id_skid_stage #(
    parameter int           N   = 32,
    parameter int           PCW = 2*N,
    parameter logic [N-1:0] NOP = 32'h0000_0013
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [PCW-1:0] pc_next,
    input  logic [N-1:0]   instruction_next,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [PCW-1:0] pc_actual,
    output logic [N-1:0]   instruction_actual,
    output logic [1:0]     occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    // Source selected for the main (output) register on the next edge.
    typedef enum logic [1:0] {
        MAIN_HOLD = 2'd0,
        MAIN_IN   = 2'd1,
        MAIN_SKID = 2'd2,
        MAIN_NOP  = 2'd3
    } main_sel_t;

    state_t         state;
    state_t         state_nxt;
    main_sel_t      main_sel;
    logic           skid_load;
    logic           accept;
    logic           consume;
    logic [PCW-1:0] skid_pc;
    logic [N-1:0]   skid_instr;

    // Occupancy count encoded by each state.
    function automatic logic [1:0] occ_of(input state_t s);
        case (s)
            EMPTY:   occ_of = 2'd0;
            ONE:     occ_of = 2'd1;
            FULL:    occ_of = 2'd2;
            default: occ_of = 2'd0;
        endcase
    endfunction

    // Handshakes use the registered ready/valid, never the partner's signal.
    assign accept  = in_valid & in_ready;
    assign consume = out_valid & out_ready;

    // Next state and data steering; flush overrides every other event.
    always_comb begin
        state_nxt = state;
        main_sel  = MAIN_HOLD;
        skid_load = 1'b0;
        if (flush) begin
            // A same-cycle consume is still delivered; a same-cycle accept is dropped.
            state_nxt = EMPTY;
            main_sel  = MAIN_NOP;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state_nxt = ONE;
                        main_sel  = MAIN_IN;
                    end
                end
                ONE: begin
                    if (accept && consume) begin
                        main_sel = MAIN_IN;
                    end else if (accept) begin
                        // Decode stalled: park the new beat behind the held one.
                        state_nxt = FULL;
                        skid_load = 1'b1;
                    end else if (consume) begin
                        state_nxt = EMPTY;
                        main_sel  = MAIN_NOP;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a consume can happen.
                    if (consume) begin
                        state_nxt = ONE;
                        main_sel  = MAIN_SKID;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                    main_sel  = MAIN_NOP;
                end
            endcase
        end
    end

    // Control FSM with its handshake and occupancy outputs registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            occupancy <= 2'd0;
        end else begin
            state     <= state_nxt;
            out_valid <= (state_nxt != EMPTY);
            in_ready  <= (state_nxt != FULL);
            occupancy <= occ_of(state_nxt);
        end
    end

    // Main register feeds decode and falls back to a PC-0 NOP bubble whenever empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_actual          <= '0;
            instruction_actual <= NOP;
        end else begin
            case (main_sel)
                MAIN_IN: begin
                    pc_actual          <= pc_next;
                    instruction_actual <= instruction_next;
                end
                MAIN_SKID: begin
                    pc_actual          <= skid_pc;
                    instruction_actual <= skid_instr;
                end
                MAIN_NOP: begin
                    pc_actual          <= '0;
                    instruction_actual <= NOP;
                end
                default: begin
                    pc_actual          <= pc_actual;
                    instruction_actual <= instruction_actual;
                end
            endcase
        end
    end

    // Skid register only matters in FULL and never reaches the outputs unpromoted, so it has no reset.
    always_ff @(posedge clk) begin
        if (skid_load) begin
            skid_pc    <= pc_next;
            skid_instr <= instruction_next;
        end
    end

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Scoreboard bench for if_id_skid_stage: the driver issues directed beats and
// queues the PCs decode must receive. The monitor keeps a reference FIFO model,
// compares every output on the falling edge and pops expected deliveries.
module tb_if_id_skid_stage;

    localparam int           N   = 32;
    localparam int           PCW = 64;
    localparam logic [31:0]  NOP = 32'h0000_0013;

    logic           clk;
    logic           rst;
    logic           flush;
    logic           in_valid;
    logic           in_ready;
    logic [PCW-1:0] pc_next;
    logic [N-1:0]   instruction_next;
    logic           out_valid;
    logic           out_ready;
    logic [PCW-1:0] pc_actual;
    logic [N-1:0]   instruction_actual;
    logic [1:0]     occupancy;

    typedef struct packed {
        logic [PCW-1:0] pc;
        logic [N-1:0]   ins;
    } ent_t;

    ent_t           mq[$];      // reference contents of the stage
    logic [PCW-1:0] exp_q[$];   // hand-listed PCs decode must receive
    int             checks;
    int             errors;
    int             acc_cnt;
    logic           done;
    logic           rnd_mode;

    if_id_skid_stage #(.N(N), .PCW(PCW), .NOP(NOP)) dut (
        .clk                (clk),
        .rst                (rst),
        .flush              (flush),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .pc_next            (pc_next),
        .instruction_next   (instruction_next),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .pc_actual          (pc_actual),
        .instruction_actual (instruction_actual),
        .occupancy          (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N-1:0] ins_of(input logic [PCW-1:0] pc);
        ins_of = {pc[11:0], 20'h00093};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compare outputs against the model, then advance the model for the coming edge.
    always @(negedge clk) begin : mon
        logic cons;
        logic acc;
        if (rst) mq.delete();
        chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
        chk("in_ready",  64'(in_ready),  64'(mq.size() < 2));
        chk("occupancy", 64'(occupancy), 64'(mq.size()));
        if (mq.size() != 0) begin
            chk("pc_actual",   64'(pc_actual),          64'(mq[0].pc));
            chk("instruction", 64'(instruction_actual), 64'(mq[0].ins));
        end else begin
            chk("pc_bubble",  64'(pc_actual),          64'd0);
            chk("nop_bubble", 64'(instruction_actual), 64'(NOP));
        end
        if (!rst) begin
            cons = (mq.size() != 0) && out_ready;
            acc  = in_valid && (mq.size() < 2);
            if (cons) begin
                if (!rnd_mode) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_delivery actual=%0h required=none at %0t", pc_actual, $time);
                    end else begin
                        chk("delivered_pc", 64'(pc_actual), 64'(exp_q.pop_front()));
                    end
                end
                void'(mq.pop_front());
            end
            if (flush) mq.delete();
            else if (acc) mq.push_back('{pc: pc_next, ins: instruction_next});
            if (acc) acc_cnt++;
        end
        if (done) begin
            chk("expected_drained", 64'(exp_q.size()), 64'd0);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    task automatic offer(input logic [PCW-1:0] pc);
        in_valid         = 1'b1;
        pc_next          = pc;
        instruction_next = ins_of(pc);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_acc();
        int base;
        int n;
        base = acc_cnt;
        n    = 0;
        do begin
            @(posedge clk);
            n++;
        end while (acc_cnt == base && n < 100);
        if (acc_cnt == base) begin
            $display("FAIL accept_timeout actual=no_accept required=accept pc=%0h", pc_next);
            $fatal(1, "accept timeout");
        end
        #1;
    endtask

    // Directed stimulus followed by a random soak.
    initial begin
        checks = 0; errors = 0; acc_cnt = 0;
        done = 1'b0; rnd_mode = 1'b0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        pc_next = '0; instruction_next = '0;
        idle(3);
        rst = 1'b0;

        // Streaming with decode always ready.
        out_ready = 1'b1;
        exp_q.push_back(64'h0); exp_q.push_back(64'h4);
        exp_q.push_back(64'h8); exp_q.push_back(64'hC);
        offer(64'h0); wait_acc();
        offer(64'h4); wait_acc();
        offer(64'h8); wait_acc();
        offer(64'hC); wait_acc();
        in_valid = 1'b0;
        idle(3);

        // Backpressure: 0x104 parks in the skid, 0x108 waits at fetch.
        exp_q.push_back(64'h100); exp_q.push_back(64'h104); exp_q.push_back(64'h108);
        offer(64'h100); wait_acc();
        out_ready = 1'b0;
        offer(64'h104); wait_acc();
        offer(64'h108);
        idle(3);
        out_ready = 1'b1;
        wait_acc();
        in_valid = 1'b0;
        idle(4);

        // Flush while FULL with a beat offered; only 0x300 afterwards is delivered.
        out_ready = 1'b0;
        offer(64'h180); wait_acc();
        offer(64'h184); wait_acc();
        offer(64'h200); flush = 1'b1;
        idle(1);
        flush = 1'b0; in_valid = 1'b0;
        idle(1);
        exp_q.push_back(64'h300);
        out_ready = 1'b1;
        offer(64'h300); wait_acc();
        in_valid = 1'b0;
        idle(3);

        // Accept plus consume in ONE, then consume plus flush.
        exp_q.push_back(64'h400); exp_q.push_back(64'h404);
        offer(64'h400); wait_acc();
        offer(64'h404); wait_acc();
        in_valid = 1'b0; flush = 1'b1;
        idle(1);
        flush = 1'b0;
        idle(2);

        // Flush in ONE discards the beat accepted in the same cycle.
        out_ready = 1'b0;
        offer(64'h500); wait_acc();
        offer(64'h504); flush = 1'b1;
        idle(1);
        flush = 1'b0; in_valid = 1'b0;
        idle(2);
        exp_q.push_back(64'h508);
        out_ready = 1'b1;
        offer(64'h508); wait_acc();
        in_valid = 1'b0;
        idle(3);

        // Asynchronous reset in FULL, asserted between clock edges.
        out_ready = 1'b0;
        offer(64'h600); wait_acc();
        offer(64'h604); wait_acc();
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // Random soak against the reference model.
        rnd_mode = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            in_valid         = ($urandom_range(0, 3) != 0);
            out_ready        = ($urandom_range(0, 3) != 0);
            flush            = ($urandom_range(0, 31) == 0);
            pc_next          = 64'(i) << 2;
            instruction_next = ins_of(64'(i) << 2) ^ 32'($urandom_range(0, 255));
            idle(1);
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        idle(4);
        done = 1'b1;
    end

    // Watchdog so the run can never hang.
    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/if_id_skid_stage.md
# if_id_skid_stage

Parametrised IF→ID pipeline stage for the RISC-V core: a two-entry skid register with valid/ready handshaking on both sides, synchronous flush with NOP injection, and an occupancy indication. It sits between instruction fetch and decode, replacing the plain clocked PC/instruction register. Fetch and decode can stall independently without combinational ready paths between stages, and branch or jump redirects can kill in-flight instructions.

## Interface
- `N`, 32: instruction width in bits.
- `PCW`, 2*N: PC width in bits.
- `NOP`, 32'h0000_0013: instruction value presented whenever no valid instruction is held (ADDI x0,x0,0).

Ports:
- `clk` in 1: clock. All state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `flush` in 1: synchronous kill of all held and incoming instructions.
- `in_valid` in 1: fetch presents a valid instruction.
- `in_ready` out 1: stage can accept an instruction this cycle.
- `pc_next` in PCW: PC of the incoming instruction.
- `instruction_next` in N: incoming instruction word.
- `out_valid` out 1: decode-side instruction is valid.
- `out_ready` in 1: decode consumes the instruction this cycle.
- `pc_actual` out PCW: PC presented to decode.
- `instruction_actual` out N: instruction presented to decode.
- `occupancy` out 2: number of held instructions, 0 to 2.

## Operation
- Storage: main register (drives the outputs) and skid register, each holding PC and instruction.
- State is EMPTY, ONE or FULL. `occupancy` is 0, 1 or 2 respectively.
- `out_valid` = (state != EMPTY). `in_ready` = (state != FULL). Both decode from state registers only; no combinational path from `out_ready` to `in_ready`.
- Accept = `in_valid & in_ready`. Consume = `out_valid & out_ready`.
- Transitions when `flush`=0:
  - EMPTY + accept → ONE; main ← input.
  - ONE + accept + consume → ONE; main ← input.
  - ONE + accept + no consume → FULL; skid ← input, main unchanged.
  - ONE + consume + no accept → EMPTY.
  - FULL + consume → ONE; main ← skid. No accept is possible in FULL.
  - All other cases hold state and data.
- Ordering is strictly FIFO. An instruction is never duplicated or dropped except by flush.
- Flush has highest priority over all other events:
  - next state is EMPTY;
  - an input beat accepted in the same cycle is discarded;
  - a consume in the same cycle still counts as delivered to decode.
- Whenever state becomes EMPTY, by consume, flush or reset, main is loaded with PC=0 and instruction=`NOP`. Decode therefore always sees a harmless bubble while `out_valid`=0.
- Skid contents are don't-care outside FULL. They must never appear on the outputs unless promoted.

## Timing
- Reset values, asserted asynchronously: state EMPTY, `out_valid`=0, `in_ready`=1, `occupancy`=0, `pc_actual`=0, `instruction_actual`=`NOP`.
- Deassertion of `rst` is synchronised externally. The first accept can occur at the first clock edge after deassertion.
- Latency: an instruction accepted at edge k appears on the outputs with `out_valid`=1 after edge k, provided it is first in line.
- Throughput: one instruction per cycle sustained while `out_ready`=1.
- Stall: after `out_ready` falls, one further beat is absorbed into the skid. `in_ready` drops after that edge.
- Un-stall from FULL: `in_ready` returns to 1 one cycle after the consume edge.
- Flush: `out_valid`=0 and `in_ready`=1 from the edge on which `flush` is sampled. The next instruction may be accepted in the following cycle.
- Reset mid-operation (any state, including FULL): contents are discarded immediately. Outputs go to the reset values without waiting for a clock edge.

## Test plan
- Reset and idle: assert `rst` mid-FULL, between edges → immediately `out_valid`=0, `occupancy`=0, `in_ready`=1, `instruction_actual`=32'h00000013, `pc_actual`=0.
- Streaming: feed PCs 0x0, 0x4, 0x8, 0xC with `out_ready`=1 held → each appears one cycle after acceptance, in order, with no bubbles.
- Backpressure: stream 0x100, 0x104, 0x108 while dropping `out_ready` after 0x100 is presented → FULL holds 0x100 (main) and 0x104 (skid), `in_ready`=0, 0x108 held at fetch. On release, decode sees 0x100, 0x104, 0x108 consecutively.
- Flush in FULL with `in_valid`=1 (PC 0x200) → next cycle `occupancy`=0, `instruction_actual`=NOP. 0x200 is never presented. A following PC 0x300 appears normally.
- Simultaneous accept and consume in ONE → `occupancy` stays 1 and the new PC appears next cycle. Consume plus flush in the same cycle → old instruction counted delivered, stage EMPTY.
- Random `in_valid`/`out_ready`/`flush` for 10k cycles against a scoreboard → FIFO order preserved, no loss except flushed beats, `occupancy` always in 0..2.
